// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Splits a cache-line transaction from the arbiter into BURST_W-wide beats on the
//   physical-memory port and reassembles read beats back into a full line. One
//   transaction in flight; requests are only accepted while idle.
//
// Ports
//   clk, rst                 : clock (rising edge), asynchronous active-low reset
//   line_read, line_write    : line requests, held by the arbiter until line_resp
//   line_addr, line_wdata    : line address (low 5 bits ignored) and write line
//   line_rdata, line_resp    : last completed read line, one-cycle completion pulse
//   burst_read, burst_write  : memory requests, held for the whole burst
//   burst_addr, burst_wdata  : line-aligned burst address, current write beat
//   burst_rdata, burst_resp  : read beat and per-beat handshake from memory
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_read,
    input  logic               line_write,
    input  logic [31:0]        line_addr,
    input  logic [LINE_W-1:0]  line_wdata,
    output logic [LINE_W-1:0]  line_rdata,
    output logic               line_resp,
    output logic               burst_read,
    output logic               burst_write,
    output logic [31:0]        burst_addr,
    output logic [BURST_W-1:0] burst_wdata,
    input  logic [BURST_W-1:0] burst_rdata,
    input  logic               burst_resp
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [26:0]        addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [LINE_W-1:0]  buf_q, buf_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;

    logic accept;
    logic beat;
    logic rd_beat;
    logic unused_addr_bits;

    // Line offset bits never reach memory; bursts are always line aligned.
    assign unused_addr_bits = ^line_addr[4:0];

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (line_write) begin
                    state_d = StWr;
                end else if (line_read) begin
                    state_d = StRd;
                end
            end
            StRd, StWr: begin
                if (burst_resp && (cnt_q == 2'd3)) begin
                    state_d = StDone;
                end
            end
            // Requests are not sampled here so a request held through line_resp
            // cannot be accepted a second time.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        burst_read  = (state_q == StRd);
        burst_write = (state_q == StWr);
        line_resp   = (state_q == StDone);
        burst_addr  = {addr_q, 5'b0};
        burst_wdata = wdata_q[32'(cnt_q) * BURST_W +: BURST_W];
        line_rdata  = rdata_q;
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        accept  = (state_q == StIdle) && (line_read || line_write);
        beat    = ((state_q == StRd) || (state_q == StWr)) && burst_resp;
        rd_beat = (state_q == StRd) && burst_resp;

        addr_d  = accept ? line_addr[31:5] : addr_q;
        wdata_d = ((state_q == StIdle) && line_write) ? line_wdata : wdata_q;

        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = 2'd0;
        end else if (beat) begin
            cnt_d = cnt_q + 2'd1;
        end

        // Beats assemble in a scratch buffer so line_rdata only changes once a
        // whole line has arrived.
        buf_d = buf_q;
        if (rd_beat) begin
            buf_d[32'(cnt_q) * BURST_W +: BURST_W] = burst_rdata;
        end

        rdata_d = rdata_q;
        if (rd_beat && (cnt_q == 2'd3)) begin
            rdata_d = buf_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: stimulus pushes expected beats and line
// responses into queues, a negedge monitor pops and compares whenever the DUT
// presents a beat handshake or a line_resp.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_addr;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    cacheline_adaptor #(
        .LINE_W  (256),
        .BURST_W (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_read   (line_read),
        .line_write  (line_write),
        .line_addr   (line_addr),
        .line_wdata  (line_wdata),
        .line_rdata  (line_rdata),
        .line_resp   (line_resp),
        .burst_read  (burst_read),
        .burst_write (burst_write),
        .burst_addr  (burst_addr),
        .burst_wdata (burst_wdata),
        .burst_rdata (burst_rdata),
        .burst_resp  (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [63:0] wdata;
    } beat_t;

    beat_t        beat_q[$];
    logic [255:0] resp_q[$];
    logic [255:0] model_rdata;
    int           n_cmp;
    int           n_bad;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- monitor
    logic [255:0] mon_line;
    beat_t        mon_beat;

    always @(negedge clk) begin
        if (line_resp) begin
            if (resp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_line_resp: got line_resp=1 want 0");
            end else begin
                mon_line = resp_q.pop_front();
                check("line_rdata", line_rdata, mon_line);
            end
        end
        if ((burst_read || burst_write) && burst_resp) begin
            if (beat_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got handshake want none");
            end else begin
                mon_beat = beat_q.pop_front();
                check("beat_kind", 256'(burst_write), 256'(mon_beat.is_wr));
                check("beat_addr", 256'(burst_addr), 256'(mon_beat.addr));
                if (mon_beat.is_wr) begin
                    check("burst_wdata", 256'(burst_wdata), 256'(mon_beat.wdata));
                end
            end
        end
    end

    // One line transaction starting at the current cycle (cycle 0). Returns at the
    // cycle after line_resp with requests dropped.
    task automatic txn(input bit is_wr, input logic [31:0] addr, input logic [255:0] wline,
                       input logic [255:0] rline, input int g0, input int g1, input int g2,
                       input int g3, input bit rd_also);
        int           gaps[4];
        logic [31:0]  exp_addr;
        logic [255:0] prev;
        beat_t        eb;
        gaps     = '{g0, g1, g2, g3};
        exp_addr = addr & 32'hFFFF_FFE0;
        prev     = model_rdata;
        line_write = is_wr;
        line_read  = !is_wr || rd_also;
        line_addr  = addr;
        line_wdata = wline;
        if (!is_wr) model_rdata = rline;
        resp_q.push_back(model_rdata);
        tick();
        check("req_read", 256'(burst_read), 256'(!is_wr));
        check("req_write", 256'(burst_write), 256'(is_wr));
        check("burst_addr", 256'(burst_addr), 256'(exp_addr));
        // Changing inputs mid-transaction must not disturb the latched copies.
        line_addr  = ~addr;
        line_wdata = ~wline;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                burst_resp  = 1'b0;
                burst_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
                tick();
                check("req_held", 256'(is_wr ? burst_write : burst_read), 256'(1));
            end
            burst_resp  = 1'b1;
            burst_rdata = rline[b*64 +: 64];
            eb.is_wr = is_wr;
            eb.addr  = exp_addr;
            eb.wdata = wline[b*64 +: 64];
            beat_q.push_back(eb);
            tick();
            if (b == 0 && !is_wr) check("rdata_hold", line_rdata, prev);
        end
        burst_resp = 1'b0;
        check("done_resp", 256'(line_resp), 256'(1));
        check("done_rd_low", 256'(burst_read), 256'(0));
        check("done_wr_low", 256'(burst_write), 256'(0));
        tick();
        line_read  = 1'b0;
        line_write = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp"}, 256'(line_resp), 256'(0));
        check({tag, "_bread"}, 256'(burst_read), 256'(0));
        check({tag, "_bwrite"}, 256'(burst_write), 256'(0));
        check({tag, "_baddr"}, 256'(burst_addr), 256'(0));
        check({tag, "_bwdata"}, 256'(burst_wdata), 256'(0));
        check({tag, "_rdata"}, line_rdata, 256'(0));
    endtask

    logic [255:0] rl1, rl2, rl3, wl1, wl2;
    beat_t        rb;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_rdata = '0;
        rl1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        rl2 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
               64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        rl3 = {64'hF00D_0000_0000_0003, 64'hF00D_0000_0000_0002,
               64'hF00D_0000_0000_0001, 64'hF00D_0000_0000_0000};
        wl1 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        wl2 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
               64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};

        rst         = 1'b0;
        line_read   = 1'b0;
        line_write  = 1'b0;
        line_addr   = '0;
        line_wdata  = '0;
        burst_rdata = '0;
        burst_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Spurious burst_resp while idle.
        burst_resp  = 1'b1;
        burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("idle_spur_rd", 256'(burst_read), 256'(0));
        check("idle_spur_wr", 256'(burst_write), 256'(0));
        tick();
        burst_resp = 1'b0;
        check("idle_spur_resp", 256'(line_resp), 256'(0));
        check("idle_spur_rdata", line_rdata, 256'(0));

        // Read, no stalls; request held through line_resp then dropped.
        txn(1'b0, 32'h0000_1234, '0, rl1, 0, 0, 0, 0, 1'b0);
        tick();
        check("no_reaccept_rd", 256'(burst_read), 256'(0));
        check("no_reaccept_resp", 256'(line_resp), 256'(0));

        // Read with burst_resp pattern 1,0,0,1,0,1,1.
        txn(1'b0, 32'h0000_4560, '0, rl2, 0, 2, 1, 0, 1'b0);

        // Write back-to-back with a stall; line_rdata must remain rl2.
        txn(1'b1, 32'h8000_0040, wl1, '0, 0, 1, 0, 0, 1'b0);

        // Read and write together: write wins.
        txn(1'b1, 32'h0000_011F, wl2, '0, 0, 0, 0, 0, 1'b1);

        // Back-to-back read issued the cycle after line_resp.
        txn(1'b0, 32'hFFFF_FFE7, '0, rl3, 0, 0, 0, 0, 1'b0);
        tick();
        check("idle_after_b2b", 256'(burst_read), 256'(0));

        // Reset mid-read after two beats.
        line_read = 1'b1;
        line_addr = 32'h0000_2000;
        tick();
        for (int b = 0; b < 2; b++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'h5555_0000_0000_0000 | 64'(b);
            rb.is_wr = 1'b0;
            rb.addr  = 32'h0000_2000;
            rb.wdata = '0;
            beat_q.push_back(rb);
            tick();
        end
        burst_resp = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        line_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_rdata = '0;
        burst_resp  = 1'b1;
        burst_rdata = 64'h7777_7777_7777_7777;
        tick();
        check("post_rst_rd", 256'(burst_read), 256'(0));
        tick();
        burst_resp = 1'b0;
        check("post_rst_resp", 256'(line_resp), 256'(0));
        check("post_rst_rdata", line_rdata, 256'(0));

        // Normal read after reset.
        txn(1'b0, 32'h0000_3008, '0, rl1, 1, 0, 0, 0, 1'b0);

        tick();
        tick();
        check("resp_q_empty", 256'(resp_q.size()), 256'(0));
        check("beat_q_empty", 256'(beat_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts 256-bit cache-line transactions from the memory-side arbiter into four 64-bit bursts on the physical-memory port, and reassembles read bursts back into a line. It sits directly downstream of the I/D arbiter and consumes its `pmem_*` requests. It returns one line-sized response per transaction. At most one transaction is in flight; a request is only accepted in IDLE.

## Interface
- `LINE_W`, default 256: cache-line width.
- `BURST_W`, default 64: memory beat width. Beats per line = LINE_W/BURST_W = 4.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. It asserts immediately and is released synchronously by the integrator.
- `line_read` in 1: line read request from the arbiter, held until `line_resp`.
- `line_write` in 1: line write request from the arbiter, held until `line_resp`.
- `line_addr` in 32: line address. Bits [4:0] are ignored.
- `line_wdata` in LINE_W: write line.
- `line_rdata` out LINE_W: assembled read line.
- `line_resp` out 1: one-cycle completion pulse.
- `burst_read` out 1: memory read request.
- `burst_write` out 1: memory write request.
- `burst_addr` out 32: memory address = {latched line_addr[31:5], 5'b0}.
- `burst_wdata` out BURST_W: current write beat.
- `burst_rdata` in BURST_W: read beat, valid when `burst_resp`=1.
- `burst_resp` in 1: beat handshake from memory.

## Operation
- **States:** IDLE, RD, WR, DONE. Beat counter `cnt` is 2 bits.
- **IDLE:**
  - If `line_write`=1, latch addr and wdata, set cnt=0, go to WR.
  - Otherwise, if `line_read`=1, latch addr, set cnt=0, go to RD.
  - Write has priority when both requests are high.
  - `burst_resp` is ignored in IDLE.
- **RD:**
  - `burst_read`=1 and `burst_addr` are held stable for the whole state.
  - Each cycle with `burst_resp`=1 stores `burst_rdata` into line slice [64*cnt+63 : 64*cnt], then cnt++.
  - After the beat with cnt=3 is captured, go to DONE.
  - Beat order is ascending: beat0 = bits [63:0].
- **WR:**
  - `burst_write`=1, `burst_addr` is held, and `burst_wdata` = latched wdata slice[cnt].
  - Each `burst_resp`=1 advances cnt.
  - After the beat with cnt=3 is accepted, go to DONE.
- **DONE:** `line_resp`=1 for exactly this cycle; go to IDLE unconditionally. New requests are not sampled in DONE. This lets the arbiter drop its request in the `line_resp` cycle without causing a re-accept.
- `line_rdata` is registered. It holds the last completed read line until the next read completes; writes do not modify it.
- Inputs `line_addr`/`line_wdata` changing mid-transaction have no effect, because they are latched at accept.
- **Reset (async, any state):**
  - state=IDLE, cnt=0, and all outputs are 0: `line_resp`, `burst_read`, `burst_write`, `burst_addr`, `burst_wdata`, `line_rdata`.
  - An in-flight burst is abandoned. Beats arriving after reset release are ignored, since the block is in IDLE.

## Timing
- **Accept:** request high in IDLE at cycle 0 → `burst_read`/`burst_write` high from cycle 1.
- **Beats:** captured at the rising edge of each cycle with `burst_resp`=1. Gaps of any length between beats are allowed; outputs are held steady during them.
- **Minimum latency:** beats at cycles 1–4 → `line_resp` at cycle 5, with `burst_read`/`burst_write` low at cycle 5.
- **Back-to-back:** next request seen at cycle 6 → burst request at cycle 7.
- **Outputs:** all outputs are driven from registers or state decode only. There is no combinational path from `burst_resp` to `burst_*` request outputs or to `line_resp`.

## Test plan
- **Read, no stalls:**
  - Stimulus: `line_read`, addr 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on cycles 1–4.
  - Required: `burst_addr`=0x0000_1220; `line_resp` at cycle 5 only; `line_rdata`={0x44..,0x33..,0x22..,0x11..}.
- **Read with stalls:**
  - Stimulus: `burst_resp` pattern 1,0,0,1,0,1,1.
  - Required: exactly 4 beats captured in order; `line_resp` one cycle after the 4th beat; `burst_read` held continuously.
- **Write:**
  - Stimulus: `line_wdata`=0xDDDD…_CCCC…_BBBB…_AAAA…, addr 0x8000_0040.
  - Required: `burst_wdata` is 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD… on successive acks; `burst_addr`=0x8000_0040; `line_resp` pulse; `line_rdata` unchanged.
- **Simultaneous and back-to-back requests:**
  - Stimulus: `line_read`=`line_write`=1 → required: WR taken.
  - Stimulus: read held through the `line_resp` cycle and then dropped → required: no second transaction.
  - Stimulus: a new read at cycle 6 → required: `burst_read` at cycle 7.
- **Reset mid-read:**
  - Stimulus: `rst`=0 asserted after 2 beats, asynchronously between edges.
  - Required: all outputs 0 immediately; no `line_resp`; stray `burst_resp` after release ignored; a subsequent read completes normally.
- **Spurious `burst_resp` in IDLE:**
  - Stimulus: `burst_resp` asserted while idle.
  - Required: no state change and no `line_resp`.
